// File: rtl/half_life_ctrl_if.sv
// Control/status bundle between the half-life sequencer, the pin-side controller and the counter datapath.
// Master drives commands and the counter value; slave (the sequencer) drives strobes and status.
interface half_life_ctrl_if #(
    parameter int WIDTH = 4,
    parameter int PER_W = 8
);
    logic             start;
    logic             abort;
    logic             tick_en;
    logic [WIDTH-1:0] init_val;
    logic [PER_W-1:0] period;
    logic [WIDTH-1:0] cnt_val;
    logic             cnt_load;
    logic [WIDTH-1:0] cnt_load_val;
    logic             cnt_down;
    logic             busy;
    logic             done;
    logic             err;
    logic [3:0]       halvings;

    modport master (
        output start, abort, tick_en, init_val, period, cnt_val,
        input  cnt_load, cnt_load_val, cnt_down, busy, done, err, halvings
    );

    modport slave (
        input  start, abort, tick_en, init_val, period, cnt_val,
        output cnt_load, cnt_load_val, cnt_down, busy, done, err, halvings
    );
endinterface

// File: rtl/half_life_ctrl.sv
// Half-life timer sequencer: loads N0, waits a period of ticks, steps the counter down to half, repeats to 0.
// Moore strobes one cycle wide; one decrement in flight at a time, checked before the next is issued.
module half_life_ctrl #(
    parameter int WIDTH = 4,
    parameter int PER_W = 8
) (
    input  logic            clk,
    input  logic            reset,
    half_life_ctrl_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SETTLE,
        S_WAIT,
        S_STEP,
        S_CHECK,
        S_DONE
    } state_e;

    localparam int STEP_W = WIDTH + 1;
    localparam logic [STEP_W-1:0] STEP_MAX = STEP_W'(1) << (WIDTH - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] n0_q, n0_d;
    logic [PER_W-1:0] per_q, per_d;
    logic [WIDTH-1:0] target_q, target_d;
    logic [PER_W-1:0] timer_q, timer_d;
    logic [STEP_W-1:0] steps_q, steps_d;
    logic [3:0]       halv_q, halv_d;
    logic             err_q, err_d;

    always_comb begin
        state_d  = state_q;
        n0_d     = n0_q;
        per_d    = per_q;
        target_d = target_q;
        timer_d  = timer_q;
        steps_d  = steps_q;
        halv_d   = halv_q;
        err_d    = err_q;

        if (bus.abort) begin
            state_d = S_IDLE;
        end else begin
            unique case (state_q)
                S_IDLE, S_DONE: begin
                    if (bus.start) begin
                        state_d = S_LOAD;
                        n0_d    = bus.init_val;
                        per_d   = (bus.period == '0) ? PER_W'(1) : bus.period;
                        halv_d  = '0;
                        err_d   = 1'b0;
                        steps_d = '0;
                    end
                end
                S_LOAD: begin
                    state_d = S_SETTLE;
                end
                S_SETTLE: begin
                    if (bus.cnt_val == '0) begin
                        state_d = S_DONE;
                    end else begin
                        timer_d = '0;
                        state_d = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (bus.tick_en) begin
                        timer_d = timer_q + PER_W'(1);
                        if (timer_q == per_q - PER_W'(1)) begin
                            target_d = bus.cnt_val >> 1;
                            state_d  = S_STEP;
                        end
                    end
                end
                S_STEP: begin
                    steps_d = steps_q + STEP_W'(1);
                    state_d = S_CHECK;
                end
                S_CHECK: begin
                    if (bus.cnt_val == target_q) begin
                        if (halv_q != 4'hF) begin
                            halv_d = halv_q + 4'd1;
                        end
                        steps_d = '0;
                        if (bus.cnt_val == '0) begin
                            state_d = S_DONE;
                        end else begin
                            timer_d = '0;
                            state_d = S_WAIT;
                        end
                    end else if ((bus.cnt_val < target_q) || (steps_q > STEP_MAX)) begin
                        // Counter overshot or never converges: flag and give up on the run.
                        err_d   = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_STEP;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            n0_q     <= '0;
            per_q    <= '0;
            target_q <= '0;
            timer_q  <= '0;
            steps_q  <= '0;
            halv_q   <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            n0_q     <= n0_d;
            per_q    <= per_d;
            target_q <= target_d;
            timer_q  <= timer_d;
            steps_q  <= steps_d;
            halv_q   <= halv_d;
            err_q    <= err_d;
        end
    end

    // Strobes are masked while reset is held so no command escapes in the reset cycle.
    assign bus.cnt_load     = (state_q == S_LOAD) && !reset;
    assign bus.cnt_down     = (state_q == S_STEP) && !reset;
    assign bus.cnt_load_val = n0_q;
    assign bus.busy         = (state_q != S_IDLE) && (state_q != S_DONE);
    assign bus.done         = (state_q == S_DONE);
    assign bus.err          = err_q;
    assign bus.halvings     = halv_q;
endmodule

// File: tb/tb_half_life_ctrl.sv
// Bench for half_life_ctrl: directed scenarios plus randomized runs against a half-life arithmetic model.
module tb_half_life_ctrl;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    half_life_ctrl_if #(.WIDTH(4), .PER_W(8)) u_if ();

    half_life_ctrl #(.WIDTH(4), .PER_W(8)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (u_if.slave)
    );

    int errors = 0;
    int checks = 0;

    // Counter datapath model and stimulus controls
    logic [3:0] cnt_next;
    int fault_drop;
    int tick_mode;
    int tick_phase;

    // Observations gathered while a run progresses
    int since_load, wait_ph, ticks_cur, steps_cur, downs, busy_cyc, loads;
    logic [3:0] prev_halv;
    logic [3:0] last_load_val;
    int steps_q[$];
    int ticks_q[$];

    // Model expectations
    int exp_steps[$];
    int exp_h, exp_busy, exp_pe;

    task automatic clear_obs();
        since_load = 3; wait_ph = 0; ticks_cur = 0; steps_cur = 0;
        downs = 0; busy_cyc = 0; loads = 0; tick_phase = 0;
        prev_halv = u_if.halvings;
        steps_q.delete();
        ticks_q.delete();
    endtask

    task automatic run_cycle();
        @(posedge clk);
        #1;
        u_if.cnt_val = cnt_next;
        if (u_if.busy) busy_cyc++;
        if (u_if.cnt_load) begin
            loads++;
            since_load = 0;
            last_load_val = u_if.cnt_load_val;
        end else if (since_load < 3) begin
            since_load++;
        end
        if (since_load == 2 && u_if.busy) begin
            wait_ph = 1; ticks_cur = 0;
        end
        if (u_if.cnt_down) begin
            if (wait_ph != 0) ticks_q.push_back(ticks_cur);
            wait_ph = 0; steps_cur++; downs++;
        end
        if (u_if.halvings != prev_halv) begin
            if (u_if.halvings == 4'(prev_halv + 4'd1)) steps_q.push_back(steps_cur);
            steps_cur = 0;
            if (u_if.busy) begin
                wait_ph = 1; ticks_cur = 0;
            end
        end
        prev_halv = u_if.halvings;
        cnt_next = u_if.cnt_val;
        if (u_if.cnt_load) begin
            cnt_next = u_if.cnt_load_val;
        end else if (u_if.cnt_down) begin
            cnt_next = u_if.cnt_val - 4'd1;
            if (fault_drop != 0) begin
                cnt_next = cnt_next - 4'd1;
                fault_drop = 0;
            end
        end
        case (tick_mode)
            0: u_if.tick_en = 1'b1;
            1: u_if.tick_en = 1'($urandom_range(0, 1));
            default: u_if.tick_en = ((tick_phase % 4) == 3);
        endcase
        tick_phase++;
        if (wait_ph != 0 && u_if.tick_en) ticks_cur++;
    endtask

    task automatic launch(input logic [3:0] n, input logic [7:0] p, output int timed_out);
        clear_obs();
        u_if.init_val = n;
        u_if.period   = p;
        u_if.start    = 1'b1;
        run_cycle();
        u_if.start    = 1'b0;
        u_if.init_val = ~n;
        u_if.period   = 8'd200;
        timed_out = 1;
        for (int c = 0; c < 2000; c++) begin
            run_cycle();
            if (!u_if.busy) begin
                timed_out = 0;
                break;
            end
        end
    endtask

    task automatic model_run(input int n, input int p);
        int v, s;
        exp_steps.delete();
        exp_pe = (p == 0) ? 1 : p;
        exp_busy = 2;
        v = n;
        while (v > 0) begin
            s = v - v / 2;
            exp_steps.push_back(s);
            exp_busy += exp_pe + 2 * s;
            v = v / 2;
        end
        exp_h = exp_steps.size();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) run_cycle();
        checks++; if (u_if.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b expected 0", u_if.busy); end
        checks++; if (u_if.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %0b expected 0", u_if.done); end
        checks++; if ({u_if.err, u_if.halvings, u_if.cnt_load, u_if.cnt_down, u_if.cnt_load_val} !== 11'd0) begin
            errors++; $display("FAIL reset_outs: got %0h expected 0", {u_if.err, u_if.halvings, u_if.cnt_load, u_if.cnt_down, u_if.cnt_load_val});
        end
        reset = 1'b0;
        run_cycle();
    endtask

    task automatic test_basic();
        int to;
        int ref_steps[4] = '{6, 3, 2, 1};
        int ok;
        tick_mode = 0;
        launch(4'd12, 8'd3, to);
        checks++; if (to != 0) begin errors++; $display("FAIL basic_timeout: got busy expected done"); end
        checks++; if (u_if.done !== 1'b1 || u_if.err !== 1'b0) begin errors++; $display("FAIL basic_status: got done=%0b err=%0b expected done=1 err=0", u_if.done, u_if.err); end
        checks++; if (u_if.halvings !== 4'd4) begin errors++; $display("FAIL basic_halvings: got %0d expected 4", u_if.halvings); end
        checks++; if (downs != 12) begin errors++; $display("FAIL basic_downs: got %0d expected 12", downs); end
        ok = (steps_q.size() == 4);
        if (ok != 0) for (int i = 0; i < 4; i++) if (steps_q[i] != ref_steps[i]) ok = 0;
        checks++; if (ok == 0) begin errors++; $display("FAIL basic_steps: got %p expected 6,3,2,1", steps_q); end
        checks++; if (busy_cyc != 38) begin errors++; $display("FAIL basic_busy_cycles: got %0d expected 38", busy_cyc); end
        checks++; if (loads != 1 || last_load_val !== 4'd12) begin errors++; $display("FAIL basic_load: got loads=%0d val=%0d expected 1/12", loads, last_load_val); end
        checks++; if (cnt_next !== 4'd0) begin errors++; $display("FAIL basic_final_count: got %0d expected 0", cnt_next); end
    endtask

    task automatic test_zero_init();
        int to;
        tick_mode = 0;
        launch(4'd0, 8'd5, to);
        checks++; if (to != 0 || u_if.done !== 1'b1) begin errors++; $display("FAIL zero_done: got done=%0b expected 1", u_if.done); end
        checks++; if (downs != 0 || u_if.halvings !== 4'd0) begin errors++; $display("FAIL zero_work: got downs=%0d halv=%0d expected 0/0", downs, u_if.halvings); end
        checks++; if (busy_cyc != 2) begin errors++; $display("FAIL zero_busy_cycles: got %0d expected 2", busy_cyc); end
    endtask

    task automatic test_period_zero();
        int to;
        tick_mode = 0;
        launch(4'd1, 8'd0, to);
        checks++; if (to != 0 || u_if.done !== 1'b1 || u_if.halvings !== 4'd1) begin errors++; $display("FAIL per0_status: got done=%0b halv=%0d expected 1/1", u_if.done, u_if.halvings); end
        checks++; if (ticks_q.size() != 1 || ticks_q[0] != 1) begin errors++; $display("FAIL per0_ticks: got %p expected 1", ticks_q); end
        checks++; if (downs != 1 || busy_cyc != 5) begin errors++; $display("FAIL per0_timing: got downs=%0d busy=%0d expected 1/5", downs, busy_cyc); end
    endtask

    task automatic test_slow_tick();
        int to;
        int ok;
        tick_mode = 2;
        launch(4'd2, 8'd2, to);
        ok = (ticks_q.size() == 2);
        foreach (ticks_q[i]) if (ticks_q[i] != 2) ok = 0;
        checks++; if (ok == 0) begin errors++; $display("FAIL slow_ticks: got %p expected 2,2", ticks_q); end
        checks++; if (to != 0 || u_if.done !== 1'b1 || u_if.halvings !== 4'd2) begin errors++; $display("FAIL slow_status: got done=%0b halv=%0d expected 1/2", u_if.done, u_if.halvings); end
        checks++; if (busy_cyc < 14) begin errors++; $display("FAIL slow_duration: got %0d expected at least 14", busy_cyc); end
        tick_mode = 0;
    endtask

    task automatic test_abort();
        int to;
        tick_mode = 0;
        clear_obs();
        u_if.init_val = 4'd12; u_if.period = 8'd3; u_if.start = 1'b1;
        run_cycle();
        u_if.start = 1'b0;
        run_cycle();
        run_cycle();
        checks++; if (u_if.busy !== 1'b1 || u_if.cnt_down !== 1'b0) begin errors++; $display("FAIL abort_wait_busy: got busy=%0b expected 1", u_if.busy); end
        u_if.abort = 1'b1;
        run_cycle();
        u_if.abort = 1'b0;
        checks++; if (u_if.busy !== 1'b0 || u_if.done !== 1'b0) begin errors++; $display("FAIL abort_wait_idle: got busy=%0b done=%0b expected 0/0", u_if.busy, u_if.done); end
        clear_obs();
        repeat (10) run_cycle();
        checks++; if (downs != 0 || loads != 0) begin errors++; $display("FAIL abort_quiet: got downs=%0d loads=%0d expected 0/0", downs, loads); end
        // abort during LOAD still lets the load strobe out
        u_if.start = 1'b1; u_if.init_val = 4'd5;
        run_cycle();
        u_if.start = 1'b0; u_if.abort = 1'b1;
        #1;
        checks++; if (u_if.cnt_load !== 1'b1) begin errors++; $display("FAIL abort_load_strobe: got %0b expected 1", u_if.cnt_load); end
        run_cycle();
        u_if.abort = 1'b0;
        checks++; if (u_if.busy !== 1'b0) begin errors++; $display("FAIL abort_load_idle: got %0b expected 0", u_if.busy); end
        launch(4'd1, 8'd1, to);
        u_if.start = 1'b1; u_if.abort = 1'b1;
        run_cycle();
        u_if.start = 1'b0; u_if.abort = 1'b0;
        checks++; if (u_if.done !== 1'b0 || u_if.busy !== 1'b0 || u_if.cnt_load !== 1'b0) begin
            errors++; $display("FAIL abort_done: got done=%0b busy=%0b load=%0b expected 0/0/0", u_if.done, u_if.busy, u_if.cnt_load);
        end
        clear_obs();
        repeat (4) run_cycle();
        checks++; if (loads != 0 || downs != 0) begin errors++; $display("FAIL abort_done_quiet: got loads=%0d downs=%0d expected 0/0", loads, downs); end
    endtask

    task automatic test_fault();
        int to;
        tick_mode = 0;
        fault_drop = 1;
        launch(4'd2, 8'd1, to);
        checks++; if (to != 0 || u_if.err !== 1'b1 || u_if.done !== 1'b0 || u_if.busy !== 1'b0) begin
            errors++; $display("FAIL fault_err: got err=%0b done=%0b busy=%0b expected 1/0/0", u_if.err, u_if.done, u_if.busy);
        end
        checks++; if (u_if.halvings !== 4'd0) begin errors++; $display("FAIL fault_halvings: got %0d expected 0", u_if.halvings); end
        clear_obs();
        u_if.init_val = 4'd3; u_if.period = 8'd1; u_if.start = 1'b1;
        run_cycle();
        u_if.start = 1'b0;
        checks++; if (u_if.err !== 1'b0) begin errors++; $display("FAIL fault_clear: got %0b expected 0", u_if.err); end
    endtask

    task automatic test_reset_midrun();
        int to;
        tick_mode = 0;
        launch(4'd7, 8'd2, to);
        clear_obs();
        u_if.init_val = 4'd9; u_if.start = 1'b1;
        run_cycle();
        u_if.start = 1'b0;
        reset = 1'b1;
        #1;
        checks++; if (u_if.cnt_load !== 1'b0) begin errors++; $display("FAIL reset_strobe: got %0b expected 0", u_if.cnt_load); end
        run_cycle();
        reset = 1'b0;
        checks++; if ({u_if.busy, u_if.done, u_if.err, u_if.halvings, u_if.cnt_load_val} !== 11'd0) begin
            errors++; $display("FAIL reset_midrun: got %0h expected 0", {u_if.busy, u_if.done, u_if.err, u_if.halvings, u_if.cnt_load_val});
        end
    endtask

    task automatic test_random();
        int to, n, p, ok;
        for (int it = 0; it < 10; it++) begin
            n = $urandom_range(0, 15);
            p = $urandom_range(0, 5);
            tick_mode = $urandom_range(0, 1);
            model_run(n, p);
            launch(4'(n), 8'(p), to);
            checks++; if (to != 0 || u_if.done !== 1'b1 || u_if.err !== 1'b0) begin
                errors++; $display("FAIL rand_status n=%0d p=%0d: got done=%0b err=%0b expected 1/0", n, p, u_if.done, u_if.err);
            end
            checks++; if (u_if.halvings !== 4'(exp_h) || downs != n) begin
                errors++; $display("FAIL rand_counts n=%0d p=%0d: got halv=%0d downs=%0d expected %0d/%0d", n, p, u_if.halvings, downs, exp_h, n);
            end
            ok = (steps_q.size() == exp_steps.size());
            if (ok != 0) foreach (exp_steps[i]) if (steps_q[i] != exp_steps[i]) ok = 0;
            checks++; if (ok == 0) begin errors++; $display("FAIL rand_steps n=%0d: got %p expected %p", n, steps_q, exp_steps); end
            ok = (ticks_q.size() == exp_h);
            foreach (ticks_q[i]) if (ticks_q[i] != exp_pe) ok = 0;
            checks++; if (ok == 0) begin errors++; $display("FAIL rand_ticks n=%0d p=%0d: got %p expected %0d each", n, p, ticks_q, exp_pe); end
            if (tick_mode == 0) begin
                checks++; if (busy_cyc != exp_busy) begin errors++; $display("FAIL rand_busy n=%0d p=%0d: got %0d expected %0d", n, p, busy_cyc, exp_busy); end
            end
        end
        tick_mode = 0;
    endtask

    initial begin
        reset = 1'b1;
        u_if.start = 1'b0; u_if.abort = 1'b0; u_if.tick_en = 1'b0;
        u_if.init_val = '0; u_if.period = '0; u_if.cnt_val = '0;
        cnt_next = '0; fault_drop = 0; tick_mode = 0; tick_phase = 0;
        last_load_val = '0;
        clear_obs();
        test_reset();
        test_basic();
        test_zero_init();
        test_period_zero();
        test_slow_tick();
        test_abort();
        test_fault();
        test_reset_midrun();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
